// File: rtl/iic_master.sv
// SCCB/I2C single-register master: one register write or read per start strobe.
// Define IIC_NACK_ABORT_EN to jump to STOP after any NACKed slave ACK slot.
module iic_master #(
   parameter logic [6:0] DEV_ADDR   = 7'h21,
   parameter int         CLK_DIV    = 50,
   parameter int         ADDR_BYTES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   inout  wire                     scl,
   inout  wire                     sda,
   input  logic                    start,
   input  logic                    rw,
   input  logic [8*ADDR_BYTES-1:0] reg_addr,
   input  logic [7:0]              wr_data,
   output logic [7:0]              rd_data,
   output logic                    busy,
   output logic                    done,
   output logic                    ack_ok
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);
   localparam logic [1:0] IDX_LA = 2'(ADDR_BYTES);
   localparam logic [1:0] IDX_DT = 2'(ADDR_BYTES + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_SEND, S_SACK, S_RSTART,
      S_RECV, S_MACK, S_STOP, S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [1:0]              qtr_q, qtr_d;
   logic [2:0]              bit_q, bit_d;
   logic [1:0]              bidx_q, bidx_d;
   logic [7:0]              tx_q, tx_d;
   logic [7:0]              rx_q, rx_d;
   logic                    rw_q, rw_d;
   logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
   logic [7:0]              data_q, data_d;
   logic                    acc_q, acc_d;
   logic                    ack_q, ack_d;
   logic [7:0]              rdd_q, rdd_d;

   logic       active, tick, smp, slot_end, abort, load;
   logic       sda_in, scl_lo, sda_lo;
   logic [1:0] sel;
   logic [7:0] byte_nx;

   assign active   = (state_q != S_IDLE) && (state_q != S_DONE);
   assign tick     = active && (cnt_q == CMAX);
   assign smp      = tick && (qtr_q == 2'd2);
   assign slot_end = tick && (qtr_q == 2'd3);
   assign sda_in   = sda;

   // Byte about to be loaded: the next index when leaving SACK, else the current one.
   always_comb begin
      sel     = (state_q == S_SACK) ? bidx_q + 2'd1 : bidx_q;
      byte_nx = {DEV_ADDR, 1'b0};
      for (int k = 1; k <= ADDR_BYTES; k++)
         if (sel == 2'(k)) byte_nx = addr_q[8*(ADDR_BYTES-k) +: 8];
      if (sel == IDX_DT) byte_nx = rw_q ? {DEV_ADDR, 1'b1} : data_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      bidx_d  = bidx_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      data_d  = data_q;
      acc_d   = acc_q;
      ack_d   = ack_q;
      rdd_d   = rdd_q;
      load    = 1'b0;
      abort   = 1'b0;
`ifdef IIC_NACK_ABORT_EN
      abort   = !acc_q;
`endif
      if (active) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick) qtr_d = qtr_q + 2'd1;
      end
      unique case (state_q)
         S_IDLE: if (start) begin
            state_d = S_START;
            rw_d    = rw;
            addr_d  = reg_addr;
            data_d  = wr_data;
            acc_d   = 1'b1;
            bidx_d  = 2'd0;
         end
         S_START: if (slot_end) begin
            state_d = S_SEND;
            load    = 1'b1;
         end
         S_SEND: if (slot_end) begin
            bit_d = bit_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
            if (bit_q == 3'd7) state_d = S_SACK;
         end
         S_SACK: begin
            if (smp && sda_in) acc_d = 1'b0;
            if (slot_end) begin
               if (abort) begin
                  state_d = S_STOP;
               end else if (bidx_q == IDX_DT) begin
                  state_d = rw_q ? S_RECV : S_STOP;
               end else if (rw_q && bidx_q == IDX_LA) begin
                  state_d = S_RSTART;
                  bidx_d  = IDX_DT;
               end else begin
                  state_d = S_SEND;
                  bidx_d  = bidx_q + 2'd1;
                  load    = 1'b1;
               end
            end
         end
         S_RSTART: if (slot_end) begin
            state_d = S_SEND;
            load    = 1'b1;
         end
         S_RECV: begin
            if (smp) rx_d = {rx_q[6:0], sda_in};
            if (slot_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_MACK;
            end
         end
         S_MACK: if (slot_end) state_d = S_STOP;
         S_STOP: if (slot_end) begin
            state_d = S_DONE;
            ack_d   = acc_q;
            if (rw_q && !abort) rdd_d = rx_q;
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            qtr_d   = 2'd0;
            bit_d   = 3'd0;
            bidx_d  = 2'd0;
         end
         default: state_d = S_IDLE;
      endcase
      if (load) tx_d = byte_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         qtr_q   <= 2'd0;
         bit_q   <= 3'd0;
         bidx_q  <= 2'd0;
         tx_q    <= 8'h00;
         rx_q    <= 8'h00;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= 8'h00;
         acc_q   <= 1'b0;
         ack_q   <= 1'b0;
         rdd_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         bidx_q  <= bidx_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         acc_q   <= acc_d;
         ack_q   <= ack_d;
         rdd_q   <= rdd_d;
      end
   end

   // Line drive per state and quarter; 1 means pull the line low.
   always_comb begin
      scl_lo = 1'b0;
      sda_lo = 1'b0;
      unique case (state_q)
         S_START: sda_lo = qtr_q[1];
         S_SEND: begin
            scl_lo = !qtr_q[1];
            sda_lo = !tx_q[7];
         end
         S_SACK, S_RECV, S_MACK: scl_lo = !qtr_q[1];
         S_RSTART: begin
            scl_lo = (qtr_q == 2'd0);
            sda_lo = qtr_q[1];
         end
         S_STOP: begin
            scl_lo = (qtr_q == 2'd0);
            sda_lo = !qtr_q[1];
         end
         default: begin
            scl_lo = 1'b0;
            sda_lo = 1'b0;
         end
      endcase
   end

   assign scl     = scl_lo ? 1'b0 : 1'bz;
   assign sda     = sda_lo ? 1'b0 : 1'bz;
   assign busy    = active;
   assign done    = (state_q == S_DONE);
   assign ack_ok  = ack_q;
   assign rd_data = rdd_q;

endmodule

// File: doc/iic_master.md
# iic_master

Parametrised SCCB/I2C single-register master for camera sensor configuration, the successor to the fixed-rate `iic_driver`. It runs one register write or one register read per request, with the sequences below:
- write: START, DEV+W, register address bytes, data, STOP
- read: START, DEV+W, register address bytes, repeated START, DEV+R, data, master NACK, STOP

It derives SCL internally from `clk` with a programmable divider, supports 8- or 16-bit register addresses, and reports per-transaction ACK status. It sits between the camera configuration sequencer and the sensor's SIO_C/SIO_D pins.

## Interface
Parameters:
- `DEV_ADDR`, 7'h21: 7-bit slave address. Write byte is {DEV_ADDR,0}=0x42; read byte is {DEV_ADDR,1}=0x43.
- `CLK_DIV`, 50: `clk` cycles per SCL quarter-period, ≥1. Bit time is 4·CLK_DIV cycles.
- `ADDR_BYTES`, 1: register address width in bytes, 1 or 2, sent MSB byte first.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `scl`  inout  1  open-drain SCL; drives 0 or `1'bz`.
- `sda`  inout  1  open-drain SDA; drives 0 or `1'bz`.
- `start`  in  1  request strobe, sampled only while idle.
- `rw`  in  1  0 = write, 1 = read; captured with `start`.
- `reg_addr`  in  8·ADDR_BYTES  register address; captured with `start`.
- `wr_data`  in  8  write data; captured with `start`.
- `rd_data`  out  8  read result; updated only at the end of a read.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse when a transaction ends.
- `ack_ok`  out  1  1 if every slave ACK slot read 0; valid from `done` until the next accepted `start`.

## Operation
- Tick generator:
  - Counts 0..CLK_DIV-1 while busy and emits a quarter tick on wrap.
  - Held at 0 when idle.
- Bit slot = 4 quarters, Q0–Q3:
  - SCL is released in Q2 and Q3, and driven low in Q0 and Q1.
  - SDA may change only at the Q0 tick.
  - SDA is sampled at the end of Q2.
- States: IDLE, START, SEND, SACK, RSTART, RECV, MACK, STOP, DONE.
  - START: SCL high throughout. SDA released in Q0–Q1, driven low in Q2–Q3.
  - SEND: 8 bits, MSB first. Driving 0 pulls SDA low; driving 1 releases it.
  - SACK: SDA released; the sampled bit is ANDed into the ack accumulator.
  - RSTART: identical to START, but SCL is low in Q0 (SDA released there).
  - RECV: SDA released, 8 bits shifted in MSB first.
  - MACK: SDA released, i.e. NACK.
  - STOP: SCL low in Q0, high in Q1–Q3. SDA driven low in Q0–Q1, released in Q2–Q3.
  - DONE: lasts one `clk` cycle. Pulses `done`, drops `busy`, returns to IDLE.
- Byte sequencer:
  - A byte index selects DEV+W, then address bytes [ADDR_BYTES-1..0], then data.
  - For reads, after the last address byte: RSTART, DEV+R, RECV, MACK.
- `start` while busy: ignored, with no queuing. `rw`, `reg_addr` and `wr_data` changes while busy have no effect.
- `start` and `done` in the same cycle: `start` is ignored; the block is not idle until the following cycle.
- SCL is never sampled; no clock stretching.

## Timing
- Reset state, applied immediately on `rst` low, including mid-transaction:
  - `scl` and `sda` both released.
  - State IDLE, all counters 0.
  - `busy` = 0, `done` = 0, `ack_ok` = 0, `rd_data` = 0x00.
- Cycle after `start` is sampled in IDLE: `busy` = 1, START Q0 begins.
- Transaction length W = 2 + 9·(2+ADDR_BYTES) bit slots for writes; R = 3 + 9·(3+ADDR_BYTES) for reads.
- `done` pulses 4·CLK_DIV·slots cycles after `busy` rises. `busy` falls in the same cycle as the `done` pulse.
- `rd_data` and `ack_ok` update in the `done` cycle.

## Configuration
- `IIC_NACK_ABORT_EN` defined: a 1 sampled in any SACK sends the FSM directly to STOP at the next Q0. Remaining bytes are skipped; `rd_data` is left unchanged; `ack_ok` = 0.
- Not defined: the full sequence always completes regardless of ACKs; only `ack_ok` reflects a NACK.

## Test plan
Bench settings: CLK_DIV=2, pull-ups on both lines.
- Write, slave model ACKs everything; `rw`=0, `reg_addr`=0x12, `wr_data`=0x80:
  - bus carries 0x42, 0x12, 0x80 with START and STOP.
  - `done` at 29·8 = 232 cycles after `busy` rises; `ack_ok` = 1.
- Read, slave returns 0xA5; `reg_addr`=0x0A:
  - bus carries 0x42, 0x0A, repeated START, 0x43, then master NACK.
  - `rd_data` = 0xA5 and `ack_ok` = 1 at `done`, 39·8 = 312 cycles.
- Slave NACKs the address byte:
  - with `IIC_NACK_ABORT_EN`: STOP follows immediately and `ack_ok` = 0.
  - without it: 232-cycle completion and `ack_ok` = 0.
- ADDR_BYTES=2 write to 0x3012: address bytes 0x30 then 0x12; `done` at 38·8 = 304 cycles.
- `start` pulsed at cycle 50 of a busy write: no effect, exactly one `done`.
- `rst` low mid-data-byte: both lines released in the same cycle and all outputs at reset values; a fresh `start` completes normally.
